// File: rtl/reg_cache_manager.sv
// Local cache of a memory-mapped register window with valid/dirty tracking, serving
// register, pointer-dereference and post-inc/dec operations over a single req/ack bus.
module reg_cache_manager #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NREG = 16,
  parameter bit WRITE_THROUGH = 1'b0,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [IDX_W-1:0]  op_reg,
  input  logic [1:0]        op_flags,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] res_ptr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);
  localparam logic [2:0] OP_READ = 3'd0, OP_READ_P = 3'd1, OP_WRITE = 3'd2,
                         OP_WRITE_P = 3'd3, OP_FLUSH = 3'd4, OP_INVAL = 3'd5;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1'b1);
  localparam logic [DATA_W-1:0] NREG_D = DATA_W'(NREG);

  typedef enum logic [2:0] {IDLE = 3'd0, BASECHK = 3'd1, FILL = 3'd2, DEREF = 3'd3,
                            WB = 3'd4, SCAN = 3'd5, RESP = 3'd6} state_t;

  state_t state, state_nx;
  logic [2:0] code, code_nx;
  logic [IDX_W-1:0] ridx, ridx_nx, widx, widx_nx, dirty_first;
  logic [1:0] flags, flags_nx;
  logic [DATA_W-1:0] wdata, wdata_nx, ptr, ptr_nx, val, val_nx, cnt, cnt_nx, hv;
  logic [ADDR_W-1:0] base_lat, base_lat_nx, base_new, base_new_nx;
  logic [DATA_W-1:0] slot [NREG];
  logic [DATA_W-1:0] slot_nx [NREG];
  logic [NREG-1:0] valid, valid_nx, dirty, dirty_nx;
  logic op_ready_nx, res_valid_nx, bus_req_nx, bus_we_nx;
  logic [DATA_W-1:0] res_data_nx, res_ptr_nx, bus_wdata_nx;
  logic [ADDR_W-1:0] bus_addr_nx;
  logic do_disp, do_have, do_post, do_resp, dirty_any;

  function automatic logic [DATA_W-1:0] adj(input logic [DATA_W-1:0] v, input logic [1:0] f);
    case (f)
      2'b01:   adj = v + ONE;
      2'b10:   adj = v - ONE;
      default: adj = v;
    endcase
  endfunction

  // Lowest-index dirty slot, so flush walks go in ascending order.
  always_comb begin
    dirty_first = '0;
    for (int i = NREG - 1; i >= 0; i--)
      dirty_first = dirty[i] ? IDX_W'(i) : dirty_first;
  end
  assign dirty_any = |dirty;

  always_comb begin
    state_nx = state;  code_nx = code;  ridx_nx = ridx;  flags_nx = flags;
    wdata_nx = wdata;  ptr_nx = ptr;  val_nx = val;  cnt_nx = cnt;  widx_nx = widx;
    base_lat_nx = base_lat;  base_new_nx = base_new;
    slot_nx = slot;  valid_nx = valid;  dirty_nx = dirty;
    op_ready_nx = op_ready;  res_valid_nx = res_valid;  res_data_nx = res_data;
    res_ptr_nx = res_ptr;  bus_req_nx = bus_req;  bus_we_nx = bus_we;
    bus_addr_nx = bus_addr;  bus_wdata_nx = bus_wdata;
    do_disp = 1'b0;  do_have = 1'b0;  do_post = 1'b0;  do_resp = 1'b0;  hv = '0;

    case (state)
      IDLE: begin
        if (op_valid && op_ready) begin
          op_ready_nx = 1'b0;
          code_nx = op_code;  ridx_nx = op_reg;  flags_nx = op_flags;  wdata_nx = op_wdata;
          if (base_addr != base_lat && |valid) begin
            base_new_nx = base_addr;
            state_nx = BASECHK;
          end else begin
            base_lat_nx = base_addr;
            do_disp = 1'b1;
          end
        end
      end
      // BASECHK and SCAN share the walk: write one dirty slot per transfer, re-scan on a low-req cycle.
      BASECHK, SCAN: begin
        if (bus_req) begin
          if (bus_ack) begin
            bus_req_nx = 1'b0;
            dirty_nx[widx] = 1'b0;
            cnt_nx = cnt + ONE;
          end
        end else if (dirty_any) begin
          bus_req_nx = 1'b1;  bus_we_nx = 1'b1;
          bus_addr_nx = base_lat + ADDR_W'(dirty_first);
          bus_wdata_nx = slot[dirty_first];
          widx_nx = dirty_first;
        end else if (state == BASECHK) begin
          valid_nx = '0;  dirty_nx = '0;
          base_lat_nx = base_new;
          do_disp = 1'b1;
        end else begin
          val_nx = cnt;
          do_resp = 1'b1;
        end
      end
      FILL: begin
        if (bus_req && bus_ack) begin
          bus_req_nx = 1'b0;
          slot_nx[ridx] = bus_rdata;  valid_nx[ridx] = 1'b1;  dirty_nx[ridx] = 1'b0;
          hv = bus_rdata;
          do_have = 1'b1;
        end
      end
      DEREF: begin
        if (!bus_req) begin
          bus_req_nx = 1'b1;  bus_we_nx = (code == OP_WRITE_P);
          bus_addr_nx = base_lat + ADDR_W'(ptr);
          bus_wdata_nx = wdata;
        end else if (bus_ack) begin
          bus_req_nx = 1'b0;
          if (code == OP_WRITE_P) begin
            val_nx = wdata;
            if (ptr < NREG_D) begin
              slot_nx[ptr[IDX_W-1:0]] = wdata;
              valid_nx[ptr[IDX_W-1:0]] = 1'b1;
              dirty_nx[ptr[IDX_W-1:0]] = 1'b0;
            end
          end else begin
            val_nx = bus_rdata;
          end
          do_post = 1'b1;
        end
      end
      WB: begin
        if (!bus_req) begin
          bus_req_nx = 1'b1;  bus_we_nx = 1'b1;
          bus_addr_nx = base_lat + ADDR_W'(ridx);
          bus_wdata_nx = slot[ridx];
        end else if (bus_ack) begin
          bus_req_nx = 1'b0;
          do_resp = 1'b1;
        end
      end
      RESP: begin
        res_valid_nx = 1'b0;
        op_ready_nx = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (do_disp) begin
      case (code_nx)
        OP_READ, OP_READ_P, OP_WRITE_P: begin
          if (valid_nx[ridx_nx]) begin
            hv = slot_nx[ridx_nx];
            do_have = 1'b1;
          end else begin
            state_nx = FILL;
            bus_req_nx = 1'b1;  bus_we_nx = 1'b0;
            bus_addr_nx = base_lat_nx + ADDR_W'(ridx_nx);
          end
        end
        OP_WRITE: begin
          slot_nx[ridx_nx] = adj(wdata_nx, flags_nx);
          valid_nx[ridx_nx] = 1'b1;
          val_nx = adj(wdata_nx, flags_nx);
          if (WRITE_THROUGH) state_nx = WB;
          else begin
            dirty_nx[ridx_nx] = 1'b1;
            do_resp = 1'b1;
          end
        end
        OP_FLUSH: begin
          cnt_nx = '0;
          if (|dirty_nx) state_nx = SCAN;
          else begin
            val_nx = '0;
            do_resp = 1'b1;
          end
        end
        OP_INVAL: begin
          valid_nx = '0;  dirty_nx = '0;  val_nx = '0;
          do_resp = 1'b1;
        end
        default: begin
          val_nx = '0;
          do_resp = 1'b1;
        end
      endcase
    end

    // The register value (pointer for the _P ops) is known; resolve the pointee if needed.
    if (do_have) begin
      ptr_nx = hv;
      case (code_nx)
        OP_READ_P: begin
          if (hv < NREG_D && valid_nx[hv[IDX_W-1:0]]) begin
            val_nx = slot_nx[hv[IDX_W-1:0]];
            do_post = 1'b1;
          end else state_nx = DEREF;
        end
        OP_WRITE_P: state_nx = DEREF;
        default: begin
          val_nx = hv;
          do_post = 1'b1;
        end
      endcase
    end

    // Post-inc/dec is applied to the original register value last, so it wins over a pointee update.
    if (do_post) begin
      if (flags_nx == 2'b01 || flags_nx == 2'b10) begin
        slot_nx[ridx_nx] = adj(ptr_nx, flags_nx);
        valid_nx[ridx_nx] = 1'b1;
        if (WRITE_THROUGH) state_nx = WB;
        else begin
          dirty_nx[ridx_nx] = 1'b1;
          do_resp = 1'b1;
        end
      end else do_resp = 1'b1;
    end

    if (do_resp) begin
      state_nx = RESP;
      res_valid_nx = 1'b1;
      res_data_nx = val_nx;
      res_ptr_nx = (code_nx == OP_READ_P || code_nx == OP_WRITE_P) ? ptr_nx : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;  code <= 3'd0;  ridx <= '0;  flags <= 2'b00;  wdata <= '0;
      ptr <= '0;  val <= '0;  cnt <= '0;  widx <= '0;  base_lat <= '0;  base_new <= '0;
      slot <= '{default: '0};  valid <= '0;  dirty <= '0;
      op_ready <= 1'b1;  res_valid <= 1'b0;  res_data <= '0;  res_ptr <= '0;
      bus_req <= 1'b0;  bus_we <= 1'b0;  bus_addr <= '0;  bus_wdata <= '0;
    end else begin
      state <= state_nx;  code <= code_nx;  ridx <= ridx_nx;  flags <= flags_nx;
      wdata <= wdata_nx;  ptr <= ptr_nx;  val <= val_nx;  cnt <= cnt_nx;  widx <= widx_nx;
      base_lat <= base_lat_nx;  base_new <= base_new_nx;
      slot <= slot_nx;  valid <= valid_nx;  dirty <= dirty_nx;
      op_ready <= op_ready_nx;  res_valid <= res_valid_nx;  res_data <= res_data_nx;
      res_ptr <= res_ptr_nx;  bus_req <= bus_req_nx;  bus_we <= bus_we_nx;
      bus_addr <= bus_addr_nx;  bus_wdata <= bus_wdata_nx;
    end
  end
endmodule

// File: tb/tb_reg_cache_manager.sv
// Directed bench for reg_cache_manager: a memory model acks the bus, a scoreboard queue
// holds expected results, and a second instance covers write-through mode.
module tb_reg_cache_manager;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] base_addr, op_wdata;
  logic        op_valid, op_valid2;
  logic [2:0]  op_code;
  logic [3:0]  op_reg;
  logic [1:0]  op_flags;

  logic op_ready, res_valid, bus_req, bus_we, bus_ack;
  logic [31:0] res_data, res_ptr, bus_addr, bus_wdata, bus_rdata;
  logic op_ready2, res_valid2, bus_req2, bus_we2, bus_ack2;
  logic [31:0] res_data2, res_ptr2, bus_addr2, bus_wdata2, bus_rdata2;

  reg_cache_manager #(.DATA_W(32), .ADDR_W(32), .NREG(16), .WRITE_THROUGH(1'b0)) dut (
    .clk(clk), .rst(rst), .base_addr(base_addr), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_reg(op_reg), .op_flags(op_flags), .op_wdata(op_wdata),
    .res_valid(res_valid), .res_data(res_data), .res_ptr(res_ptr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata));

  reg_cache_manager #(.DATA_W(32), .ADDR_W(32), .NREG(16), .WRITE_THROUGH(1'b1)) dut_wt (
    .clk(clk), .rst(rst), .base_addr(base_addr), .op_valid(op_valid2), .op_ready(op_ready2),
    .op_code(op_code), .op_reg(op_reg), .op_flags(op_flags), .op_wdata(op_wdata),
    .res_valid(res_valid2), .res_data(res_data2), .res_ptr(res_ptr2),
    .bus_req(bus_req2), .bus_we(bus_we2), .bus_addr(bus_addr2), .bus_wdata(bus_wdata2),
    .bus_ack(bus_ack2), .bus_rdata(bus_rdata2));

  typedef struct { logic [31:0] data; logic [31:0] ptr; } res_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } xfer_t;

  res_t  expq[$];
  xfer_t logq[$];
  xfer_t logq2[$];
  logic [31:0] mem [logic [31:0]];
  int checks = 0;
  int errors = 0;
  int ack_dly = 2;
  string step = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s:%s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  // Memory model for the write-back instance: acks after ack_dly cycles of bus_req.
  initial begin : responder
    int cnt;
    cnt = 0;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (bus_req && !rst) begin
        cnt++;
        if (cnt >= ack_dly) begin
          cnt = 0;
          bus_ack = 1'b1;
          if (bus_we) mem[bus_addr] = bus_wdata;
          bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
          logq.push_back('{bus_we, bus_addr, bus_we ? bus_wdata : bus_rdata});
        end
      end else cnt = 0;
    end
  end

  // Write-through instance: ack in the first cycle bus_req is seen, log every transfer.
  initial begin : responder_wt
    bus_ack2 = 1'b0;
    bus_rdata2 = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus_ack2 = 1'b0;
      if (bus_req2 && !rst) begin
        bus_ack2 = 1'b1;
        logq2.push_back('{bus_we2, bus_addr2, bus_wdata2});
      end
    end
  end

  // Scoreboard: every completion pulse pops one expected result.
  initial begin : monitor
    res_t e;
    forever begin
      @(posedge clk); #1;
      if (res_valid) begin
        if (expq.size() == 0) check("res_unexpected", 32'(res_valid), 32'd0);
        else begin
          e = expq.pop_front();
          check("res_data", res_data, e.data);
          check("res_ptr", res_ptr, e.ptr);
        end
      end
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!op_ready && guard < 200) begin guard++; @(negedge clk); end
    check("op_ready_wait", 32'(op_ready), 32'd1);
  endtask

  task automatic do_op(input logic [2:0] c, input logic [3:0] r, input logic [1:0] f,
                       input logic [31:0] wd, input logic [31:0] b,
                       input logic [31:0] exp_d, input logic [31:0] exp_p, output int lat);
    wait_ready();
    expq.push_back('{exp_d, exp_p});
    op_code = c;  op_reg = r;  op_flags = f;  op_wdata = wd;  base_addr = b;  op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    check("res_arrived", 32'(res_valid), 32'd1);
  endtask

  task automatic do_op2(input logic [2:0] c, input logic [3:0] r, input logic [1:0] f,
                        input logic [31:0] wd, input logic [31:0] b, input logic [31:0] exp_d);
    int lat;
    @(negedge clk);
    lat = 0;
    while (!op_ready2 && lat < 200) begin lat++; @(negedge clk); end
    op_code = c;  op_reg = r;  op_flags = f;  op_wdata = wd;  base_addr = b;  op_valid2 = 1'b1;
    @(posedge clk); #1;
    op_valid2 = 1'b0;
    lat = 0;
    while (!res_valid2 && lat < 300) begin @(posedge clk); #1; lat++; end
    check("wt_res_arrived", 32'(res_valid2), 32'd1);
    check("wt_res_data", res_data2, exp_d);
    check("wt_res_ptr", res_ptr2, 32'd0);
  endtask

  task automatic expect_bus(input logic we, input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    check("bus_present", 32'(logq.size() != 0), 32'd1);
    if (logq.size() != 0) begin
      x = logq.pop_front();
      check("bus_we", 32'(x.we), 32'(we));
      check("bus_addr", x.addr, a);
      check("bus_data", x.data, d);
    end
  endtask

  task automatic expect_no_bus();
    check("bus_extra", 32'(logq.size()), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int lat;
    xfer_t x;
    rst = 1'b1;  op_valid = 1'b0;  op_valid2 = 1'b0;  base_addr = 32'h0;
    op_code = 3'd0;  op_reg = 4'd0;  op_flags = 2'b00;  op_wdata = 32'h0;
    mem[32'h103] = 32'hAB;  mem[32'h101] = 32'h5;  mem[32'h105] = 32'h77;
    mem[32'h207] = 32'h99;  mem[32'h1] = 32'h42;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    step = "reset";
    check("op_ready", 32'(op_ready), 32'd1);
    check("res_valid", 32'(res_valid), 32'd0);
    check("bus_req", 32'(bus_req), 32'd0);
    check("res_data", res_data, 32'd0);
    check("bus_addr", bus_addr, 32'd0);
    check("wt_op_ready", 32'(op_ready2), 32'd1);

    step = "cold_read";
    do_op(3'd0, 4'd3, 2'b00, 32'h0, 32'h100, 32'hAB, 32'h0, lat);
    check("latency", 32'(lat), 32'd2);
    expect_bus(1'b0, 32'h103, 32'hAB);
    expect_no_bus();

    step = "hit_read";
    do_op(3'd0, 4'd3, 2'b00, 32'h0, 32'h100, 32'hAB, 32'h0, lat);
    check("latency", 32'(lat), 32'd0);
    expect_no_bus();

    step = "read_p_inc";
    do_op(3'd1, 4'd1, 2'b01, 32'h0, 32'h100, 32'h77, 32'h5, lat);
    expect_bus(1'b0, 32'h101, 32'h5);
    expect_bus(1'b0, 32'h105, 32'h77);
    expect_no_bus();

    step = "flush_one";
    do_op(3'd4, 4'd0, 2'b00, 32'h0, 32'h100, 32'h1, 32'h0, lat);
    expect_bus(1'b1, 32'h101, 32'h6);
    expect_no_bus();

    step = "read_after_inc";
    do_op(3'd0, 4'd1, 2'b00, 32'h0, 32'h100, 32'h6, 32'h0, lat);
    check("latency", 32'(lat), 32'd0);
    expect_no_bus();

    step = "write_inc_wrap";
    do_op(3'd2, 4'd2, 2'b01, 32'hFFFF_FFFF, 32'h100, 32'h0, 32'h0, lat);
    check("latency", 32'(lat), 32'd0);
    do_op(3'd2, 4'd0, 2'b00, 32'h0, 32'h100, 32'h0, 32'h0, lat);
    expect_no_bus();

    step = "write_p_override";
    do_op(3'd3, 4'd0, 2'b10, 32'h9, 32'h100, 32'h9, 32'h0, lat);
    expect_bus(1'b1, 32'h100, 32'h9);
    expect_no_bus();
    do_op(3'd0, 4'd0, 2'b00, 32'h0, 32'h100, 32'hFFFF_FFFF, 32'h0, lat);
    expect_no_bus();

    step = "write_p_pointee";
    do_op(3'd3, 4'd2, 2'b00, 32'h55, 32'h100, 32'h55, 32'h0, lat);
    expect_bus(1'b1, 32'h100, 32'h55);
    do_op(3'd0, 4'd0, 2'b00, 32'h0, 32'h100, 32'h55, 32'h0, lat);
    check("latency", 32'(lat), 32'd0);
    do_op(3'd4, 4'd0, 2'b00, 32'h0, 32'h100, 32'h1, 32'h0, lat);
    expect_bus(1'b1, 32'h102, 32'h0);
    expect_no_bus();

    step = "base_switch";
    do_op(3'd2, 4'd7, 2'b00, 32'h1234, 32'h100, 32'h1234, 32'h0, lat);
    do_op(3'd0, 4'd7, 2'b00, 32'h0, 32'h200, 32'h99, 32'h0, lat);
    expect_bus(1'b1, 32'h107, 32'h1234);
    expect_bus(1'b0, 32'h207, 32'h99);
    expect_no_bus();

    step = "addr_wrap";
    do_op(3'd0, 4'd3, 2'b00, 32'h0, 32'hFFFF_FFFE, 32'h42, 32'h0, lat);
    expect_bus(1'b0, 32'h1, 32'h42);
    expect_no_bus();

    step = "flush_empty";
    do_op(3'd4, 4'd0, 2'b00, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'h0, lat);
    check("latency", 32'(lat), 32'd0);
    step = "reserved";
    do_op(3'd6, 4'd3, 2'b00, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'h0, lat);
    check("latency", 32'(lat), 32'd0);
    expect_no_bus();

    step = "inval";
    do_op(3'd5, 4'd0, 2'b00, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'h0, lat);
    expect_no_bus();
    do_op(3'd0, 4'd3, 2'b00, 32'h0, 32'hFFFF_FFFE, 32'h42, 32'h0, lat);
    expect_bus(1'b0, 32'h1, 32'h42);

    step = "reset_mid_op";
    ack_dly = 50;
    wait_ready();
    op_code = 3'd0;  op_reg = 4'd5;  op_flags = 2'b00;  base_addr = 32'hFFFF_FFFE;  op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("bus_req_up", 32'(bus_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ack_dly = 2;
    check("bus_req", 32'(bus_req), 32'd0);
    check("op_ready", 32'(op_ready), 32'd1);
    check("res_valid", 32'(res_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1 expect_no_bus();
    do_op(3'd0, 4'd3, 2'b00, 32'h0, 32'hFFFF_FFFE, 32'h42, 32'h0, lat);
    expect_bus(1'b0, 32'h1, 32'h42);
    expect_no_bus();

    step = "write_through";
    do_op2(3'd2, 4'd4, 2'b00, 32'h10, 32'h300, 32'h10);
    check("wt_write_cnt", 32'(logq2.size()), 32'd1);
    if (logq2.size() != 0) begin
      x = logq2.pop_front();
      check("wt_write_we", 32'(x.we), 32'd1);
      check("wt_write_addr", x.addr, 32'h304);
      check("wt_write_data", x.data, 32'h10);
    end
    do_op2(3'd4, 4'd0, 2'b00, 32'h0, 32'h300, 32'h0);
    check("wt_flush_cnt", 32'(logq2.size()), 32'd0);
    do_op2(3'd0, 4'd4, 2'b01, 32'h0, 32'h300, 32'h10);
    check("wt_inc_cnt", 32'(logq2.size()), 32'd1);
    if (logq2.size() != 0) begin
      x = logq2.pop_front();
      check("wt_inc_addr", x.addr, 32'h304);
      check("wt_inc_data", x.data, 32'h11);
    end
    check("wb_quiet", 32'(logq.size()), 32'd0);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
